// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM encoding and stall-pattern encoder for the pipeline control unit.
package pipe_ctrl_pkg;

    localparam logic              Stop        = 1'b1;
    localparam logic              NoStop      = 1'b0;
    localparam logic              RstEnable   = 1'b1;
    localparam logic [31:0]       ZeroWord    = 32'h0000_0000;
    localparam int unsigned       InstAddrBus = 32;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallIF   = 6'b000011;
    localparam logic [5:0] StallID   = 6'b000111;
    localparam logic [5:0] StallEX   = 6'b001111;
    localparam logic [5:0] StallMEM  = 6'b011111;

    typedef enum logic {
        CtrlRun   = 1'b0,
        CtrlFlush = 1'b1
    } ctrl_state_e;

    // Deepest requesting stage wins; everything upstream of it stops too.
    function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        if (req_mem)     return StallMEM;
        else if (req_ex) return StallEX;
        else if (req_id) return StallID;
        else if (req_if) return StallIF;
        else             return StallNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear (clear has priority).
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector from stage requests, exception flush sequencing,
// stall-cycle statistics and a continuous-stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if_i,
    input  logic                   stallreq_id_i,
    input  logic                   stallreq_ex_i,
    input  logic                   stallreq_mem_i,
    input  logic                   excp_req_i,
    input  logic [InstAddrBus-1:0] excp_pc_i,
    output logic [5:0]             stall_o,
    output logic                   flush_o,
    output logic [InstAddrBus-1:0] new_pc_o,
    output logic [31:0]            stall_cycles_o,
    output logic                   stall_timeout_o
);

    localparam logic [15:0] RunLimit = 16'(STALL_MAX - 1);

    ctrl_state_e            state_q;
    logic                   flush_q;
    logic [InstAddrBus-1:0] new_pc_q;
    logic                   timeout_q, timeout_d;
    logic [15:0]            run_cnt;
    logic                   pc_stalled;

    always_comb begin
        stall_o = StallNone;
        if (state_q == CtrlRun) begin
            stall_o = stall_encode(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        end
    end

    assign pc_stalled = (stall_o[0] == Stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q  <= CtrlRun;
            flush_q  <= 1'b0;
            new_pc_q <= ZeroWord;
        end else begin
            unique case (state_q)
                CtrlRun: begin
                    if (excp_req_i) begin
                        state_q  <= CtrlFlush;
                        flush_q  <= 1'b1;
                        new_pc_q <= excp_pc_i;
                    end
                end
                CtrlFlush: begin
                    state_q <= CtrlRun;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= CtrlRun;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .Width(32)
    ) u_stall_cycles (
        .clk     (clk),
        .rst     (rst),
        .en_i    (pc_stalled),
        .clr_i   (1'b0),
        .count_o (stall_cycles_o)
    );

    // Counts consecutive stalled cycles; any free cycle restarts the run.
    sat_counter #(
        .Width(16)
    ) u_run_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (pc_stalled),
        .clr_i   (~pc_stalled),
        .count_o (run_cnt)
    );

    assign timeout_d = timeout_q | (pc_stalled && (run_cnt >= RunLimit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign flush_o         = flush_q;
    assign new_pc_o        = new_pc_q;
    assign stall_timeout_o = timeout_q;

endmodule
